// File: rtl/hwpe_stream_package.sv
// Shared types and constants for the hwpe-stream source-side blocks.
package hwpe_stream_package;

  localparam int unsigned TCDM_READER_DEFAULT_DEPTH = 4;
  localparam int unsigned TCDM_READER_FLAGS_CNT_W   = 8;

  typedef struct packed {
    logic                               busy;
    logic [TCDM_READER_FLAGS_CNT_W-1:0] outstanding;
  } flags_tcdm_reader_t;

endpackage

// File: rtl/hwpe_stream_tcdm_reader_fifo.sv
// Response FIFO: output taken straight from storage, so a push shows up one cycle later.
// Push and pop may coincide at any occupancy; clear_i flushes synchronously.
module hwpe_stream_tcdm_reader_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] occupancy_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid_o     = (count_q != '0);
  assign data_o      = mem_q[rd_ptr_q];
  assign occupancy_o = count_q;
  assign do_pop      = pop_i & valid_o;
  assign do_push     = push_i & ~clear_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // When full, a simultaneous pop reads the slot before the push overwrites it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(do_push && !do_pop && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/hwpe_stream_tcdm_reader.sv
// Turns an address stream into TCDM loads and returns the data as a stream.
// Outstanding + buffered + to-be-dropped responses never exceed FIFO_DEPTH, so r_valid is never stalled.
module hwpe_stream_tcdm_reader
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = TCDM_READER_DEFAULT_DEPTH,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    addr_valid_i,
  output logic                    addr_ready_o,
  input  logic [31:0]             addr_data_i,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [31:0]             tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  input  logic                    tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  output logic                    data_valid_o,
  input  logic                    data_ready_i,
  output logic [DATA_WIDTH-1:0]   data_data_o,
  output logic [DATA_WIDTH/8-1:0] data_strb_o,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        outstanding_o
);

  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   occupancy;
  logic               req_pending_q, req_pending_d;
  logic [CNT_W+1:0]   credit_sum;
  logic               credit_ok;
  logic               grant;
  logic               drop_rsp;
  logic               push;
  flags_tcdm_reader_t flags;

  assign credit_sum = (CNT_W+2)'(outstanding_q) + (CNT_W+2)'(occupancy) + (CNT_W+2)'(drop_cnt_q);
  assign credit_ok  = credit_sum < (CNT_W+2)'(FIFO_DEPTH);

  // A stalled request keeps asserting regardless of enable/credit, so the address stays stable.
  assign tcdm_req_o   = ~rst_i & addr_valid_i & ((enable_i & credit_ok) | req_pending_q);
  assign grant        = tcdm_req_o & tcdm_gnt_i;
  assign addr_ready_o = grant;
  assign tcdm_add_o   = addr_data_i;
  assign tcdm_wen_o   = 1'b1;
  assign tcdm_be_o    = '1;
  assign tcdm_data_o  = '0;

  assign drop_rsp = tcdm_r_valid_i & (drop_cnt_q != '0);
  assign push     = tcdm_r_valid_i & ~drop_rsp & ~clear_i;

  always_comb begin
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    req_pending_d = req_pending_q;
    if (clear_i) begin
      // Every response still in flight, including this cycle's grant, becomes stale.
      outstanding_d = '0;
      req_pending_d = 1'b0;
      drop_cnt_d    = drop_cnt_q + outstanding_q + CNT_W'(grant) - CNT_W'(tcdm_r_valid_i);
    end else begin
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(tcdm_r_valid_i & ~drop_rsp);
      drop_cnt_d    = drop_cnt_q - CNT_W'(drop_rsp);
      req_pending_d = tcdm_req_o & ~tcdm_gnt_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      req_pending_q <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      req_pending_q <= req_pending_d;
    end
  end

  hwpe_stream_tcdm_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CNT_W (CNT_W)
  ) i_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .push_i      (push),
    .push_data_i (tcdm_r_data_i),
    .pop_i       (data_ready_i),
    .valid_o     (data_valid_o),
    .data_o      (data_data_o),
    .occupancy_o (occupancy)
  );

  assign data_strb_o = '1;

  assign flags.busy        = (outstanding_q != '0) | (drop_cnt_q != '0) | (occupancy != '0) | req_pending_q;
  assign flags.outstanding = TCDM_READER_FLAGS_CNT_W'(outstanding_q);
  assign busy_o            = flags.busy;
  assign outstanding_o     = CNT_W'(flags.outstanding);

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Directed bench for hwpe_stream_tcdm_reader with a fixed-latency memory model.
module tb_hwpe_stream_tcdm_reader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i, clear_i;
  logic        addr_valid_i, addr_ready_o;
  logic [31:0] addr_data_i;
  logic        tcdm_req_o, tcdm_gnt_i;
  logic [31:0] tcdm_add_o;
  logic        tcdm_wen_o;
  logic [3:0]  tcdm_be_o;
  logic [31:0] tcdm_data_o;
  logic        tcdm_r_valid_i;
  logic [31:0] tcdm_r_data_i;
  logic        data_valid_o, data_ready_i;
  logic [31:0] data_data_o;
  logic [3:0]  data_strb_o;
  logic        busy_o;
  logic [2:0]  outstanding_o;

  hwpe_stream_tcdm_reader #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .addr_valid_i(addr_valid_i), .addr_ready_o(addr_ready_o), .addr_data_i(addr_data_i),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_data_o(data_data_o),
    .data_strb_o(data_strb_o), .busy_o(busy_o), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, lat = 1;
  int          n_grant = 0, n_ardy = 0, max_out = 0, t0 = 0;
  logic [31:0] src_q[$];
  int          due_q[$];
  logic [31:0] pa_q[$];
  logic [31:0] rx_q[$];
  int          rx_cyc[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    addr_valid_i = (src_q.size() != 0);
    addr_data_i  = (src_q.size() != 0) ? src_q[0] : 32'h0;
  endtask

  // Sample handshakes mid-cycle, then advance and drive memory responses just after the edge.
  task automatic tick();
    @(negedge clk_i);
    if (addr_ready_o) begin
      n_ardy++;
      if (src_q.size() != 0) void'(src_q.pop_front());
    end
    if (tcdm_req_o && tcdm_gnt_i) begin
      n_grant++;
      due_q.push_back(cyc + lat);
      pa_q.push_back(tcdm_add_o);
    end
    if (data_valid_o && data_ready_i) begin
      rx_q.push_back(data_data_o);
      rx_cyc.push_back(cyc);
    end
    if (int'(outstanding_o) > max_out) max_out = int'(outstanding_o);
    @(posedge clk_i);
    #1;
    cyc++;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i  = 32'h0;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = mem(pa_q[0]);
      void'(due_q.pop_front());
      void'(pa_q.pop_front());
    end
    drive_src();
    #1;
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; addr_valid_i = 1'b0; addr_data_i = 32'h0;
    tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_data_i = 32'h0; data_ready_i = 1'b0;

    // Reset state
    @(posedge clk_i); #1;
    check("rst_data_valid", 32'(data_valid_o), 32'd0);
    check("rst_req", 32'(tcdm_req_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_outstanding", 32'(outstanding_o), 32'd0);
    check("const_wen", 32'(tcdm_wen_o), 32'd1);
    check("const_be", 32'(tcdm_be_o), 32'hF);
    check("const_wdata", tcdm_data_o, 32'h0);
    check("const_strb", 32'(data_strb_o), 32'hF);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Streaming at 1-cycle latency
    lat = 1; enable_i = 1'b1; tcdm_gnt_i = 1'b1; data_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back(32'h100 + 32'(4 * i));
    drive_src(); t0 = cyc; max_out = 0; rx_q.delete(); rx_cyc.delete();
    #1;
    check("stream_req", 32'(tcdm_req_o), 32'd1);
    check("stream_add", tcdm_add_o, 32'h100);
    for (int k = 0; k < 40 && rx_q.size() < 8; k++) tick();
    check("stream_count", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check("stream_data", (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF, mem(32'h100 + 32'(4 * i)));
    if (rx_q.size() == 8) begin
      check("stream_fill", 32'(rx_cyc[0] - t0), 32'd2);
      check("stream_rate", 32'(rx_cyc[7] - rx_cyc[0]), 32'd7);
    end
    check("stream_max_outstanding", 32'(max_out), 32'd1);

    // Backpressure: only FIFO_DEPTH loads may be issued
    data_ready_i = 1'b0; n_grant = 0; rx_q.delete();
    for (int i = 0; i < 10; i++) src_q.push_back(32'h400 + 32'(4 * i));
    drive_src();
    repeat (8) tick();
    check("bp_grants", 32'(n_grant), 32'd4);
    check("bp_req_low", 32'(tcdm_req_o), 32'd0);
    check("bp_outstanding", 32'(outstanding_o), 32'd0);
    check("bp_valid", 32'(data_valid_o), 32'd1);
    check("bp_hold_data", data_data_o, mem(32'h400));
    check("bp_busy", 32'(busy_o), 32'd1);
    data_ready_i = 1'b1;
    for (int k = 0; k < 80 && rx_q.size() < 10; k++) tick();
    check("bp_count", 32'(rx_q.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      check("bp_data", (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF, mem(32'h400 + 32'(4 * i)));

    // Grant stall with enable dropping mid-stall
    tcdm_gnt_i = 1'b0; n_ardy = 0; rx_q.delete();
    src_q.push_back(32'h200); drive_src();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) enable_i = 1'b0;
      #1;
      check("stall_req", 32'(tcdm_req_o), 32'd1);
      check("stall_add", tcdm_add_o, 32'h200);
      check("stall_ardy", 32'(addr_ready_o), 32'd0);
      tick();
    end
    tcdm_gnt_i = 1'b1; #1;
    check("stall_grant_ardy", 32'(addr_ready_o), 32'd1);
    tick();
    check("stall_req_after", 32'(tcdm_req_o), 32'd0);
    check("stall_ardy_pulses", 32'(n_ardy), 32'd1);
    for (int k = 0; k < 10 && rx_q.size() < 1; k++) tick();
    check("stall_data", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD_BEEF, mem(32'h200));
    enable_i = 1'b1;

    // Clear with two loads in flight and one buffered response
    lat = 3; data_ready_i = 1'b0; rx_q.delete();
    src_q.push_back(32'h500); drive_src();
    repeat (3) tick();
    src_q.push_back(32'h504); src_q.push_back(32'h508); drive_src();
    repeat (2) tick();
    check("clr_pre_outstanding", 32'(outstanding_o), 32'd2);
    check("clr_pre_valid", 32'(data_valid_o), 32'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0; #1;
    check("clr_valid", 32'(data_valid_o), 32'd0);
    check("clr_outstanding", 32'(outstanding_o), 32'd0);
    check("clr_busy_drop2", 32'(busy_o), 32'd1);
    tick();
    check("clr_busy_drop1", 32'(busy_o), 32'd1);
    check("clr_drop1_valid", 32'(data_valid_o), 32'd0);
    tick();
    check("clr_busy_idle", 32'(busy_o), 32'd0);
    check("clr_drop2_valid", 32'(data_valid_o), 32'd0);
    data_ready_i = 1'b1;
    src_q.push_back(32'h300); drive_src();
    for (int k = 0; k < 20 && rx_q.size() < 1; k++) tick();
    repeat (5) tick();
    check("clr_new_count", 32'(rx_q.size()), 32'd1);
    check("clr_new_data", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD_BEEF, mem(32'h300));

    // Credit limit, grant+r_valid and push+pop in the same cycle
    lat = 2; data_ready_i = 1'b0; rx_q.delete();
    for (int i = 0; i < 5; i++) src_q.push_back(32'h700 + 32'(4 * i));
    drive_src();
    repeat (3) tick();
    check("sim_out_c3", 32'(outstanding_o), 32'd2);
    tick();
    check("sim_out_grant_rv", 32'(outstanding_o), 32'd2);
    check("sim_req_nocredit", 32'(tcdm_req_o), 32'd0);
    tick();
    check("sim_out_c5", 32'(outstanding_o), 32'd1);
    check("sim_head", data_data_o, mem(32'h700));
    data_ready_i = 1'b1;
    tick();
    check("sim_pushpop_valid", 32'(data_valid_o), 32'd1);
    check("sim_pushpop_data", data_data_o, mem(32'h704));
    for (int k = 0; k < 40 && rx_q.size() < 5; k++) tick();
    check("sim_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("sim_data", (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF, mem(32'h700 + 32'(4 * i)));

    // Asynchronous reset in the middle of a burst
    lat = 1;
    for (int i = 0; i < 6; i++) src_q.push_back(32'h800 + 32'(4 * i));
    drive_src();
    repeat (2) tick();
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_req", 32'(tcdm_req_o), 32'd0);
    check("arst_ardy", 32'(addr_ready_o), 32'd0);
    check("arst_valid", 32'(data_valid_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_outstanding", 32'(outstanding_o), 32'd0);
    src_q.delete(); due_q.delete(); pa_q.delete();
    tcdm_r_valid_i = 1'b0; drive_src();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    tick();
    check("arst_busy_after", 32'(busy_o), 32'd0);
    check("arst_valid_after", 32'(data_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
